// File: rtl/match_template_sequencer_pkg.sv
// Shared constants and state encoding for the matched-filter template sequencer.
package match_template_sequencer_pkg;

    localparam int unsigned TAPS_DEFAULT = 101;
    localparam int unsigned PARK_IDX     = 127;
    localparam int unsigned IDX_W        = 7;
    localparam int unsigned SAMPLE_W     = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LEARN    = 3'd1;
    localparam logic [2:0] ST_RUN_WAIT = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_SWEEP    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_LEARN    = ST_LEARN,
        S_RUN_WAIT = ST_RUN_WAIT,
        S_LOAD     = ST_LOAD,
        S_SWEEP    = ST_SWEEP,
        S_DONE     = ST_DONE
    } state_t;

endpackage

// File: rtl/match_template_sequencer_template_store.sv
// DEPTH x SAMPLE_W register file: one synchronous write port, one asynchronous read port.
module match_template_sequencer_template_store
    import match_template_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = TAPS_DEFAULT
) (
    input  logic                       clock,
    input  logic                       we,
    input  logic [IDX_W-1:0]           wr_addr,
    input  logic signed [SAMPLE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]           rd_addr,
    output logic signed [SAMPLE_W-1:0] rd_data
);

    logic signed [SAMPLE_W-1:0] mem [DEPTH];

    // Write the addressed row; contents need no reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_addr == IDX_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Asynchronous read mux; addresses beyond DEPTH read as zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/match_template_sequencer.sv
// Learns a heartbeat template and drives time-reversed correlation sweeps into the matched filter.
module match_template_sequencer
    import match_template_sequencer_pkg::*;
#(
    parameter int unsigned TAPS = TAPS_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       x_ready,
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic                       start_learn,
    input  logic                       run_en,
    output logic                       filt_ready,
    output logic signed [SAMPLE_W-1:0] x_out,
    output logic signed [SAMPLE_W-1:0] coeff_mf,
    output logic [IDX_W-1:0]           index,
    output logic [IDX_W-1:0]           offset,
    output logic                       sweep_done,
    output logic                       learning,
    output logic                       template_valid,
    output logic                       overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] SWEEP_BASE = IDX_W'(TAPS - 2);
    localparam logic [IDX_W-1:0] PARK       = IDX_W'(PARK_IDX);

    state_t state, state_n;

    logic                       filt_ready_n;
    logic signed [SAMPLE_W-1:0] x_out_n;
    logic signed [SAMPLE_W-1:0] coeff_mf_n;
    logic [IDX_W-1:0]           index_n;
    logic [IDX_W-1:0]           offset_n;
    logic                       sweep_done_n;
    logic                       learning_n;
    logic                       template_valid_n;
    logic                       overrun_n;
    logic [IDX_W-1:0]           wr_ptr, wr_ptr_n;
    logic                       learn_pend, learn_pend_n;

    logic                       tmpl_we;
    logic [IDX_W-1:0]           rd_addr;
    logic signed [SAMPLE_W-1:0] rd_data;

    match_template_sequencer_template_store #(
        .DEPTH (TAPS)
    ) u_template_store (
        .clock   (clock),
        .we      (tmpl_we),
        .wr_addr (wr_ptr),
        .wr_data (x),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State and registered outputs; synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            filt_ready     <= 1'b0;
            x_out          <= '0;
            coeff_mf       <= '0;
            index          <= PARK;
            offset         <= '0;
            sweep_done     <= 1'b0;
            learning       <= 1'b0;
            template_valid <= 1'b0;
            overrun        <= 1'b0;
            wr_ptr         <= '0;
            learn_pend     <= 1'b0;
        end else begin
            state          <= state_n;
            filt_ready     <= filt_ready_n;
            x_out          <= x_out_n;
            coeff_mf       <= coeff_mf_n;
            index          <= index_n;
            offset         <= offset_n;
            sweep_done     <= sweep_done_n;
            learning       <= learning_n;
            template_valid <= template_valid_n;
            overrun        <= overrun_n;
            wr_ptr         <= wr_ptr_n;
            learn_pend     <= learn_pend_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n          = state;
        filt_ready_n     = 1'b0;
        x_out_n          = x_out;
        coeff_mf_n       = coeff_mf;
        index_n          = index;
        offset_n         = offset;
        sweep_done_n     = 1'b0;
        template_valid_n = template_valid;
        overrun_n        = overrun;
        wr_ptr_n         = wr_ptr;
        learn_pend_n     = learn_pend;
        tmpl_we          = 1'b0;
        rd_addr          = LAST_IDX;

        unique case (state)
            S_IDLE: begin
                if (start_learn) begin
                    state_n          = S_LEARN;
                    wr_ptr_n         = '0;
                    template_valid_n = 1'b0;
                end else if (run_en && template_valid) begin
                    state_n = S_RUN_WAIT;
                end
            end

            S_LEARN: begin
                if (start_learn) begin
                    wr_ptr_n = '0;
                end else if (x_ready) begin
                    tmpl_we  = 1'b1;
                    wr_ptr_n = wr_ptr + IDX_W'(1);
                    if (wr_ptr == LAST_IDX) begin
                        template_valid_n = 1'b1;
                        state_n          = run_en ? S_RUN_WAIT : S_IDLE;
                    end
                end
            end

            S_RUN_WAIT: begin
                if (start_learn) begin
                    state_n          = S_LEARN;
                    wr_ptr_n         = '0;
                    template_valid_n = 1'b0;
                end else if (!run_en) begin
                    state_n = S_IDLE;
                end else if (x_ready) begin
                    state_n      = S_LOAD;
                    filt_ready_n = 1'b1;
                    x_out_n      = x;
                end
            end

            S_LOAD: begin
                if (x_ready)     overrun_n    = 1'b1;
                if (start_learn) learn_pend_n = 1'b1;
                rd_addr    = LAST_IDX;
                index_n    = '0;
                coeff_mf_n = rd_data;
                state_n    = S_SWEEP;
            end

            S_SWEEP: begin
                if (x_ready)     overrun_n    = 1'b1;
                if (start_learn) learn_pend_n = 1'b1;
                if (index == LAST_IDX) begin
                    index_n      = PARK;
                    coeff_mf_n   = '0;
                    sweep_done_n = 1'b1;
                    state_n      = S_DONE;
                end else begin
                    // Next tap reads the template back to front.
                    rd_addr    = SWEEP_BASE - index;
                    index_n    = index + IDX_W'(1);
                    coeff_mf_n = rd_data;
                end
            end

            S_DONE: begin
                if (x_ready) overrun_n = 1'b1;
                offset_n = offset + IDX_W'(1);
                if (learn_pend || start_learn) begin
                    state_n          = S_LEARN;
                    wr_ptr_n         = '0;
                    template_valid_n = 1'b0;
                    learn_pend_n     = 1'b0;
                end else begin
                    state_n = S_RUN_WAIT;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        learning_n = (state_n == S_LEARN);
    end

endmodule

// File: tb/tb_match_template_sequencer.sv
// Self-checking bench: timeline model of learn/sweep behaviour plus directed literal checks.
module tb_match_template_sequencer;

    localparam int unsigned TAPS = 4;
    localparam int M_IDLE  = 0;
    localparam int M_LEARN = 1;
    localparam int M_WAIT  = 2;
    localparam int M_BUSY  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              x_ready = 1'b0;
    logic signed [7:0] x = '0;
    logic              start_learn = 1'b0;
    logic              run_en = 1'b0;
    logic              filt_ready;
    logic signed [7:0] x_out;
    logic signed [7:0] coeff_mf;
    logic [6:0]        index;
    logic [6:0]        offset;
    logic              sweep_done;
    logic              learning;
    logic              template_valid;
    logic              overrun;

    always #5 clock = ~clock;

    match_template_sequencer #(.TAPS(TAPS)) dut (
        .clock          (clock),
        .reset          (reset),
        .x_ready        (x_ready),
        .x              (x),
        .start_learn    (start_learn),
        .run_en         (run_en),
        .filt_ready     (filt_ready),
        .x_out          (x_out),
        .coeff_mf       (coeff_mf),
        .index          (index),
        .offset         (offset),
        .sweep_done     (sweep_done),
        .learning       (learning),
        .template_valid (template_valid),
        .overrun        (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fr_cnt = 0;
    int sd_cnt = 0;

    // Model: abstract mode plus the edge at which the current sweep was accepted.
    int                cyc = 0;
    int                mode = M_IDLE;
    bit                m_started = 1'b0;
    bit                m_tv = 1'b0;
    bit                m_ovr = 1'b0;
    bit                m_pend = 1'b0;
    int                m_off = 0;
    int                m_wp = 0;
    int                m_a = 0;
    logic signed [7:0] m_ax = '0;
    logic signed [7:0] m_tmpl [TAPS];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int d;
        cyc++;
        if (reset) begin
            mode = M_IDLE; m_tv = 0; m_ovr = 0; m_off = 0; m_pend = 0; m_wp = 0;
            m_started = 1'b1;
            return;
        end
        case (mode)
            M_IDLE: begin
                if (start_learn) begin
                    mode = M_LEARN; m_wp = 0; m_tv = 0;
                end else if (run_en && m_tv) begin
                    mode = M_WAIT;
                end
            end
            M_LEARN: begin
                if (start_learn) begin
                    m_wp = 0;
                end else if (x_ready) begin
                    m_tmpl[m_wp] = x;
                    m_wp++;
                    if (m_wp == int'(TAPS)) begin
                        m_tv = 1;
                        mode = run_en ? M_WAIT : M_IDLE;
                    end
                end
            end
            M_WAIT: begin
                if (start_learn) begin
                    mode = M_LEARN; m_wp = 0; m_tv = 0;
                end else if (!run_en) begin
                    mode = M_IDLE;
                end else if (x_ready) begin
                    mode = M_BUSY; m_a = cyc; m_ax = x;
                end
            end
            default: begin
                d = cyc - m_a;
                if (x_ready) m_ovr = 1;
                if (d == int'(TAPS) + 2) begin
                    m_off = (m_off + 1) % 128;
                    if (m_pend || start_learn) begin
                        mode = M_LEARN; m_wp = 0; m_tv = 0; m_pend = 0;
                    end else begin
                        mode = M_WAIT;
                    end
                end else if (start_learn) begin
                    m_pend = 1;
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        logic [34:0] exp_v, act_v;
        int d, e_fr, e_x, e_idx, e_coef, e_sd;
        @(negedge clock);
        if (filt_ready === 1'b1) fr_cnt++;
        if (sweep_done === 1'b1) sd_cnt++;
        if (m_started) begin
            e_fr = 0; e_x = 0; e_idx = 127; e_coef = 0; e_sd = 0;
            if (mode == M_BUSY) begin
                d = cyc - m_a;
                if (d == 0) begin
                    e_fr = 1; e_x = int'(m_ax);
                end else if (d <= int'(TAPS)) begin
                    e_idx = d - 1; e_coef = int'(m_tmpl[int'(TAPS) - d]);
                end else if (d == int'(TAPS) + 1) begin
                    e_sd = 1;
                end
            end
            exp_v = {1'(e_fr), 8'(e_x), 8'(e_coef), 7'(e_idx), 7'(m_off), 1'(e_sd),
                     (mode == M_LEARN), m_tv, m_ovr};
            act_v = {filt_ready, (e_fr != 0) ? x_out : 8'h00, coeff_mf, index, offset,
                     sweep_done, learning, template_valid, overrun};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_x(input logic [7:0] v);
        x_ready = 1'b1;
        x = v;
        step();
        x_ready = 1'b0;
    endtask

    initial begin
        int                 fr0, sd0;
        logic signed [7:0]  learn_a [4];
        logic signed [7:0]  learn_b [4];
        logic signed [7:0]  learn_c [4];
        logic signed [7:0]  rev_a   [4];
        learn_a = '{8'sd10, 8'sd20, 8'sd30, 8'sd40};
        learn_b = '{8'sd1, -8'sd2, 8'sd3, -8'sd4};
        learn_c = '{8'sd2, 8'sd4, 8'sd6, 8'sd8};
        rev_a   = '{8'sd40, 8'sd30, 8'sd20, 8'sd10};

        // Reset state.
        repeat (3) step();
        check("reset_index", int'(index), 127);
        check("reset_offset", int'(offset), 0);
        check("reset_tv", int'(template_valid), 0);
        check("reset_fr", int'(filt_ready), 0);
        reset = 1'b0;
        step();

        // Learn four samples with run_en low: ends in IDLE with a valid template.
        start_learn = 1'b1; step(); start_learn = 1'b0;
        check("learning_high", int'(learning), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            pulse_x(learn_a[i]);
            step();
        end
        check("learn_tv", int'(template_valid), 1);
        check("learn_done_learning", int'(learning), 0);

        // One sweep with hand-computed timing and time-reversed coefficients.
        run_en = 1'b1;
        step(); step();
        pulse_x(8'sd5);
        check("sweep_fr", int'(filt_ready), 1);
        check("sweep_xout", int'(x_out), 5);
        for (int k = 0; k < 4; k++) begin
            step();
            check("sweep_index", int'(index), k);
            check("sweep_coeff", int'(coeff_mf), int'(rev_a[k]));
        end
        step();
        check("sweep_done_pulse", int'(sweep_done), 1);
        check("sweep_park", int'(index), 127);
        step();
        check("sweep_done_once", int'(sweep_done), 0);
        check("sweep_offset", int'(offset), 1);

        // Back-to-back sweeps at the maximum rate wrap the offset.
        fr0 = fr_cnt; sd0 = sd_cnt;
        repeat (128) begin
            pulse_x(8'($urandom));
            repeat (TAPS + 2) step();
        end
        check("wrap_offset", int'(offset), 1);
        check("wrap_fr_count", fr_cnt - fr0, 128);
        check("wrap_sd_count", sd_cnt - sd0, 128);

        // Overrun: sample arriving mid-sweep is dropped and sticks the flag.
        fr0 = fr_cnt;
        pulse_x(8'sd7);
        step(); step();
        pulse_x(8'sd9);
        check("overrun_set", int'(overrun), 1);
        repeat (3) step();
        check("overrun_sticky", int'(overrun), 1);
        check("overrun_fr_count", fr_cnt - fr0, 1);

        // Learn request at index 1 waits for the sweep to finish.
        pulse_x(8'sd3);
        step(); step();
        check("defer_at_idx1", int'(index), 1);
        start_learn = 1'b1; step(); start_learn = 1'b0;
        step(); step();
        check("defer_sd", int'(sweep_done), 1);
        check("defer_not_learning", int'(learning), 0);
        step();
        check("defer_learning", int'(learning), 1);
        check("defer_tv", int'(template_valid), 0);

        // Relearn a signed template; run_en high returns to sweeping.
        for (int i = 0; i < 4; i++) begin
            pulse_x(learn_b[i]);
            step();
        end
        check("relearn_tv", int'(template_valid), 1);
        pulse_x(-8'sd8);
        step();
        check("neg_coeff0", int'(coeff_mf), -4);
        repeat (TAPS + 1) step();

        // Reset mid-sweep at index 2.
        pulse_x(8'sd11);
        step(); step(); step();
        check("pre_reset_idx", int'(index), 2);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_index", int'(index), 127);
        check("rst_offset", int'(offset), 0);
        check("rst_coeff", int'(coeff_mf), 0);
        check("rst_flags", int'({filt_ready, sweep_done, learning, template_valid, overrun}), 0);

        // run_en without a template does not start sweeps.
        fr0 = fr_cnt;
        repeat (3) begin
            pulse_x(8'sd1);
            repeat (3) step();
        end
        check("gate_no_fr", fr_cnt - fr0, 0);

        // Simultaneous x_ready and start_learn in IDLE: sample not captured.
        x_ready = 1'b1; start_learn = 1'b1; x = 8'sd55; step();
        x_ready = 1'b0; start_learn = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            pulse_x(learn_c[i]);
            step();
        end
        pulse_x(8'sd0);
        step();
        check("simul_coeff0", int'(coeff_mf), 8);
        repeat (TAPS + 2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
